// File: rtl/gps_ca_pkg.sv
// Shared constants for the GPS L1 C/A Gold-code generator: LFSR geometry,
// feedback masks and the G2 phase-selector tap table.
package gps_ca_pkg;

  localparam int LFSR_WIDTH  = 10;
  localparam int CODE_LENGTH = 1023;

  // Bit i of a mask/state corresponds to register stage i+1 (stage 10 is the output).
  localparam logic [LFSR_WIDTH-1:0] G1_MASK   = 10'h204;
  localparam logic [LFSR_WIDTH-1:0] G2_MASK   = 10'h3A6;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 10'h3FF;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } tap_pair_t;

  // Stage numbers (1..10) as listed in the ICD, indexed by PRN-1.
  localparam tap_pair_t PRN_TAPS [32] = '{
    '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
    '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
    '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
    '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
    '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
    '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
    '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
    '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9}
  };

  function automatic logic stage_bit(input logic [LFSR_WIDTH-1:0] state,
                                     input logic [3:0] stage);
    return state[stage - 4'd1];
  endfunction

endpackage

// File: rtl/ca_lfsr.sv
// 10-bit Fibonacci LFSR shifting toward stage 10; load_ones reseeds to all ones
// and takes precedence over step.
module ca_lfsr
  import gps_ca_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] MASK = G1_MASK
) (
  input  logic                  clk,
  input  logic                  step,
  input  logic                  load_ones,
  output logic [LFSR_WIDTH-1:0] state
);

  always_ff @(posedge clk) begin
    if (load_ones) begin
      state <= LFSR_SEED;
    end else if (step) begin
      state <= {state[LFSR_WIDTH-2:0], ^(state & MASK)};
    end
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator for one channel: turns DDS phase MSB edges into
// half-chip/chip ticks and produces early/prompt/late chips, epoch and chip index.
module ca_code_gen
  import gps_ca_pkg::*;
#(
  parameter int CHIP_COUNT_WIDTH = 10,
  parameter int CODE_LENGTH      = gps_ca_pkg::CODE_LENGTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        init,
  input  logic [4:0]                  prn,
  input  logic                        phase_msb,
  output logic                        early,
  output logic                        prompt,
  output logic                        late,
  output logic                        epoch,
  output logic [CHIP_COUNT_WIDTH-1:0] chip_count
);

  logic                  msb_d;
  logic                  half_tick;
  logic                  chip_tick;
  logic                  last_chip;
  logic                  wrap;
  logic                  lfsr_load;
  logic                  lfsr_step;
  logic [4:0]            prn_reg;
  logic [LFSR_WIDTH-1:0] g1;
  logic [LFSR_WIDTH-1:0] g2;
  tap_pair_t             taps;

  assign half_tick = phase_msb ^ msb_d;
  assign chip_tick = msb_d & ~phase_msb;
  assign last_chip = (chip_count == CHIP_COUNT_WIDTH'(CODE_LENGTH - 1));
  assign wrap      = chip_tick & last_chip;

  // Reseeding covers reset, init and the epoch wrap; a tick during init is dropped.
  assign lfsr_load = reset | init | wrap;
  assign lfsr_step = chip_tick & ~last_chip;

  ca_lfsr #(.MASK(G1_MASK)) u_g1 (
    .clk      (clk),
    .step     (lfsr_step),
    .load_ones(lfsr_load),
    .state    (g1)
  );

  ca_lfsr #(.MASK(G2_MASK)) u_g2 (
    .clk      (clk),
    .step     (lfsr_step),
    .load_ones(lfsr_load),
    .state    (g2)
  );

  assign taps  = PRN_TAPS[prn_reg];
  assign early = g1[LFSR_WIDTH-1] ^ stage_bit(g2, taps.s1) ^ stage_bit(g2, taps.s2);

  always_ff @(posedge clk) begin
    if (reset) begin
      msb_d      <= 1'b0;
      prn_reg    <= 5'd0;
      chip_count <= '0;
      prompt     <= 1'b0;
      late       <= 1'b0;
      epoch      <= 1'b0;
    end else begin
      msb_d <= phase_msb;
      epoch <= 1'b0;
      if (init) begin
        prn_reg    <= prn;
        chip_count <= '0;
        prompt     <= 1'b0;
        late       <= 1'b0;
      end else begin
        if (half_tick) begin
          prompt <= early;
          late   <= prompt;
        end
        if (chip_tick) begin
          chip_count <= last_chip ? '0 : chip_count + 1'b1;
          epoch      <= last_chip;
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_code_gen.sv
// Self-checking bench for ca_code_gen: a sequence-level Gold-code model checks
// every output on every cycle, plus directed literal checks from the ICD.
module tb_ca_code_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [4:0] prn;
  logic       phase_msb;
  logic       early;
  logic       prompt;
  logic       late;
  logic       epoch;
  logic [9:0] chip_count;

  ca_code_gen #(.CHIP_COUNT_WIDTH(10), .CODE_LENGTH(1023)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .prn       (prn),
    .phase_msb (phase_msb),
    .early     (early),
    .prompt    (prompt),
    .late      (late),
    .epoch     (epoch),
    .chip_count(chip_count)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int ep_seen    = 0;

  // Gold code table, built from the output-sequence recurrences of G1 and G2.
  bit code [32][1023];
  int tap_s1 [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_s2 [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  // Behavioural state: which PRN, which chip index, and the half-tick history.
  int m_prn, m_idx;
  bit m_msb_d, m_prompt, m_late, m_epoch;

  task automatic build_codes();
    int a [1040];
    int b [1040];
    for (int n = 0; n < 10; n++) begin a[n] = 1; b[n] = 1; end
    for (int n = 0; n < 1030; n++) begin
      a[n+10] = a[n+7] ^ a[n];
      b[n+10] = b[n+8] ^ b[n+7] ^ b[n+4] ^ b[n+2] ^ b[n+1] ^ b[n];
    end
    for (int p = 0; p < 32; p++)
      for (int n = 0; n < 1023; n++)
        code[p][n] = bit'(a[n] ^ b[n+10-tap_s1[p]] ^ b[n+10-tap_s2[p]]);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply the rules to the inputs seen at the edge, then compare.
  task automatic cyc();
    logic r, i, p, ht, ct;
    logic [4:0] pv;
    @(posedge clk);
    r = reset; i = init; p = phase_msb; pv = prn;
    if (r) begin
      m_prn = 0; m_idx = 0; m_prompt = 0; m_late = 0; m_epoch = 0; m_msb_d = 0;
    end else if (i) begin
      m_prn = int'(pv); m_idx = 0; m_prompt = 0; m_late = 0; m_epoch = 0; m_msb_d = p;
    end else begin
      ht = p ^ m_msb_d;
      ct = m_msb_d & ~p;
      m_epoch = 0;
      if (ht) begin
        m_late   = m_prompt;
        m_prompt = code[m_prn][m_idx];
      end
      if (ct) begin
        if (m_idx == 1022) begin m_idx = 0; m_epoch = 1; end
        else m_idx++;
      end
      m_msb_d = p;
    end
    #1;
    check("early",      32'(early),      32'(code[m_prn][m_idx]));
    check("prompt",     32'(prompt),     32'(m_prompt));
    check("late",       32'(late),       32'(m_late));
    check("epoch",      32'(epoch),      32'(m_epoch));
    check("chip_count", 32'(chip_count), 32'(m_idx));
    if (epoch === 1'b1) ep_seen++;
    @(negedge clk);
  endtask

  task automatic step_half();
    phase_msb = ~phase_msb;
    repeat (4) cyc();
  endtask

  task automatic chip();
    step_half();
    step_half();
  endtask

  task automatic do_init(input int p);
    init = 1'b1;
    prn  = 5'(p);
    cyc();
    init = 1'b0;
  endtask

  task automatic capture10(output logic [9:0] w);
    w = '0;
    for (int k = 0; k < 10; k++) begin
      w = {w[8:0], early};
      chip();
    end
  endtask

  logic [9:0] first10 [4] = '{10'o1440, 10'o1620, 10'o1710, 10'o1744};

  initial begin
    logic [9:0] w;
    logic [9:0] exp_w;
    int ones, e0, cc, old_early, new_early;

    build_codes();
    // Pin the model itself to ICD values.
    for (int p = 0; p < 4; p++) begin
      w = '0;
      for (int n = 0; n < 10; n++) w = {w[8:0], code[p][n]};
      check($sformatf("model_first10_prn%0d", p + 1), 32'(w), 32'(first10[p]));
    end
    ones = 0;
    for (int n = 0; n < 1023; n++) ones += int'(code[0][n]);
    check("model_ones_prn1", ones, 512);

    reset = 1'b1; init = 1'b0; phase_msb = 1'b0; prn = 5'd0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("reset_early", 32'(early), 1);
    check("reset_count", 32'(chip_count), 0);

    // First ten chips for PRN1..4, phase toggling every 4 cycles.
    for (int p = 0; p < 4; p++) begin
      do_init(p);
      capture10(w);
      check($sformatf("first10_prn%0d", p + 1), 32'(w), 32'(first10[p]));
      check("count_after10", 32'(chip_count), 10);
    end

    // Two epochs of PRN1.
    do_init(0);
    e0 = ep_seen;
    ones = 0;
    for (int c = 0; c < 2100; c++) begin
      if (c < 1023) ones += int'(early);
      chip();
    end
    check("epoch_ones", ones, 512);
    check("epoch_pulses", ep_seen - e0, 2);
    check("count_after2100", 32'(chip_count), 2100 - 2046);

    // Re-init mid-epoch, then reset mid-stream.
    do_init(0);
    repeat (500) chip();
    check("count_500", 32'(chip_count), 500);
    e0 = ep_seen;
    do_init(5);
    check("reinit_count", 32'(chip_count), 0);
    check("reinit_epoch", 32'(epoch), 0);
    exp_w = '0;
    for (int n = 0; n < 10; n++) exp_w = {exp_w[8:0], code[5][n]};
    capture10(w);
    check("first10_prn6", 32'(w), 32'(exp_w));
    check("reinit_no_epoch", ep_seen - e0, 0);
    phase_msb = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midreset_early", 32'(early), 1);
    check("midreset_prompt", 32'(prompt), 0);
    check("midreset_late", 32'(late), 0);
    check("midreset_epoch", 32'(epoch), 0);
    check("midreset_count", 32'(chip_count), 0);

    // Freeze with phase held high, then a one-cycle glitch.
    phase_msb = 1'b0;
    repeat (3) cyc();
    do_init(1);
    repeat (7) chip();
    phase_msb = 1'b1;
    repeat (4) cyc();
    cc = int'(chip_count);
    check("hold_start_count", cc, 7);
    old_early = int'(code[1][7]);
    new_early = int'(code[1][8]);
    repeat (200) cyc();
    check("hold_count", 32'(chip_count), 7);
    check("hold_early", 32'(early), 32'(old_early));
    phase_msb = 1'b0;
    cyc();
    phase_msb = 1'b1;
    repeat (3) cyc();
    check("glitch_count", 32'(chip_count), 8);
    check("glitch_prompt", 32'(prompt), 32'(new_early));
    check("glitch_late", 32'(late), 32'(old_early));
    repeat (10) chip();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
GPS L1 C/A Gold-code generator for one tracking channel, directly downstream of the code-rate DDS.
- Consumes the DDS phase MSB; each MSB transition is a half-chip boundary, each 1->0 transition (accumulator wrap) is a chip boundary.
- Produces early/prompt/late chips with half-chip spacing, a 1023-chip epoch pulse and the current chip index for the correlators.

Parameters:
CHIP_COUNT_WIDTH, 10, width of chip_count output
CODE_LENGTH, 1023, chips per code epoch

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
init  input  1  one-cycle pulse: latch prn, restart code at chip 0
prn  input  5  satellite select minus one (0 = PRN1 ... 31 = PRN32), sampled only on init
phase_msb  input  1  top output bit of the code DDS
early  output  1  current code chip, combinational from LFSR registers
prompt  output  1  early delayed by one half-chip tick
late  output  1  early delayed by two half-chip ticks
epoch  output  1  one-cycle pulse at the chip 0 boundary
chip_count  output  CHIP_COUNT_WIDTH  index of the chip on early, 0..1022

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Priority: reset > init > tick processing.
- Reset:
  - G1 = G2 = 10'h3FF; prn_reg = 0; chip_count = 0; prompt = late = 0; epoch = 0; msb_d = 0.
  - early therefore reads 1 after reset, since all-ones LFSRs output 1.
- Edge detect: msb_d <= phase_msb every cycle.
  - half_tick = phase_msb ^ msb_d.
  - chip_tick = msb_d & ~phase_msb.
- Rate constraint on the DDS: inc < 2^(ACC_WIDTH-1), so at most one transition per cycle. The block does not check this.
- G1: x^10+x^3+1. Shift toward bit 10; feedback = G1[3]^G1[10].
- G2: x^10+x^9+x^8+x^6+x^3+x^2+1. Feedback = G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10].
- Chip value: early = G1[10] ^ G2[s1] ^ G2[s2], with (s1,s2) taken from the PRN tap table indexed by prn_reg (ICD-GPS-200, e.g. PRN1 = (2,6), PRN2 = (3,7)).
- On chip_tick:
  - If chip_count == CODE_LENGTH-1: chip_count <= 0, G1 <= G2 <= 10'h3FF, epoch <= 1.
  - Otherwise: both LFSRs step and chip_count increments.
  - The new chip appears on early in the cycle after the edge at which chip_tick was sampled.
- epoch is high for exactly one cycle, aligned with chip 0 appearing on early.
- On half_tick (both edges): prompt <= early (value before any LFSR update at the same edge); late <= prompt.
  - Net result: prompt lags early by 1/2 chip, late lags by 1 chip.
- init:
  - prn_reg <= prn; LFSRs <= 10'h3FF; chip_count <= 0; prompt = late = 0; epoch = 0; msb_d <= phase_msb, so the init cycle produces no spurious tick.
  - A tick coincident with init is discarded.
  - init never raises epoch.
- phase_msb held constant: all state frozen except msb_d.
- A single-cycle glitch on phase_msb counts as two half-ticks plus possibly one chip_tick. This is legal and must not corrupt state.

Decomposition:
- Package gps_ca_pkg holds:
  - LFSR width 10, CODE_LENGTH 1023, G1 and G2 feedback masks.
  - 32-entry G2 phase-selector tap table (s1, s2 pairs).
- Sub-module ca_lfsr (10-bit Fibonacci LFSR):
  - Parameters: feedback mask.
  - Inputs: step and load_ones.
  - Instantiated twice, once for G1 and once for G2.
- The top level holds the edge detect, chip counter, PRN tap mux and the prompt/late shift register.

Test Plan:
1. Reset, init with prn=0, toggle phase_msb every 4 cycles -> first 10 chips on early = 1100100000 (octal 1440), chip_count 0..9.
2. init with prn=1 / prn=2 / prn=3 -> first 10 chips 1110010000 / 1111001000 / 1111100100 (octal 1620 / 1710 / 1744).
3. PRN1, run 2100 chips:
   - epoch pulses exactly once every 1023 chip_ticks, each one cycle wide, when chip_count wraps 1022->0.
   - 512 ones per epoch.
   - Second epoch is bit-identical to the first.
4. At every half_tick -> prompt equals early sampled one half_tick earlier, late equals early two half_ticks earlier; at a chip boundary early and prompt differ in value for exactly one half-chip interval.
5. Mid-epoch at chip 500:
   - init with prn=5 -> chip_count=0, no epoch pulse, PRN6 sequence from chip 0.
   - Then assert reset -> next cycle early=1, prompt=late=epoch=0, chip_count=0.
6. Hold phase_msb=1 for 200 cycles -> no output change. A 1-cycle 1->0->1 glitch -> exactly one chip advance and two prompt/late shifts.
